ncl_mult_seq: RTL

Parametrised, clocked successor to the fixed 3×3 NCL multiplier: multiplies two W-bit dual-rail operands and returns a 2W-bit dual-rail product, keeping the four-phase Ki/Ko NULL/DATA handshake of the NCL datapath. Internally it synchronises the asynchronous rails, captures a complete DATA wavefront, runs a W-cycle shift-add FSM, and presents the product only when downstream requests DATA. It sits at the boundary between the NCL multiplier pipeline and the clocked test/control logic.

---
 rtl/ncl_mult_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ncl_mult_seq.sv
// Clocked dual-rail NCL multiplier: synchronised Ki/Ko handshake and a W-cycle shift-add core.
// Optional macro NCL_ILLEGAL_CHECK_EN enables sticky detection of illegal 11 rail pairs on err.
module ncl_mult_seq #(
    parameter int W      = 3,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     a_rail1,
    input  logic [W-1:0]     a_rail0,
    input  logic [W-1:0]     b_rail1,
    input  logic [W-1:0]     b_rail0,
    input  logic             Ki,
    output logic             Ko,
    output logic [2*W-1:0]   p_rail1,
    output logic [2*W-1:0]   p_rail0,
    output logic             err
);
    localparam int PW = 2 * W;
    localparam int NR = 4 * W;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MULT    = 2'd1,
        HOLD    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NR-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic            ki1_q, ki1_d, ki2_q, ki2_d;
    logic            ko_q, ko_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d, a_sh_q, a_sh_d;
    logic [PW-1:0]   p1_q, p1_d, p0_q, p0_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    a1_s, a0_s, b1_s, b0_s;
    logic            complete_s, allnull_s, stable_s, blocked_s;

    assign {a1_s, a0_s, b1_s, b0_s} = sync2_q;
    assign complete_s = (&(a1_s ^ a0_s)) & (&(b1_s ^ b0_s));
    assign allnull_s  = ~|sync2_q;
    assign stable_s   = (sync2_q == prev_q);

`ifdef NCL_ILLEGAL_CHECK_EN
    logic [PW-1:0] ill_now_s, ill_prev_s;
    assign ill_now_s  = {a1_s & a0_s, b1_s & b0_s};
    assign ill_prev_s = {prev_q[4*W-1:3*W] & prev_q[3*W-1:2*W],
                         prev_q[2*W-1:W]   & prev_q[W-1:0]};
    assign blocked_s  = err_q;
`else
    assign blocked_s  = 1'b0;
`endif

    // Two-flop synchronisers plus the previous-sample copy used for the stability compare
    always_comb begin
        sync1_d = {a_rail1, a_rail0, b_rail1, b_rail0};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        ki1_d   = Ki;
        ki2_d   = ki1_q;
    end

    // Handshake FSM, shift-add datapath and output rail control
    always_comb begin
        state_d = state_q;
        ko_d    = ko_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        p1_d    = p1_q;
        p0_d    = p0_q;
`ifdef NCL_ILLEGAL_CHECK_EN
        err_d   = err_q | (|(ill_now_s & ill_prev_s));
`else
        err_d   = 1'b0;
`endif

        // Ko release is independent of state; it may coincide with the PRESENT->IDLE step
        if (!ko_q && allnull_s && !blocked_s) begin
            ko_d = 1'b1;
        end else begin
            ko_d = ko_q;
        end

        case (state_q)
            IDLE: begin
                if (ko_q && (p1_q == {PW{1'b0}}) && (p0_q == {PW{1'b0}}) &&
                    complete_s && stable_s && !blocked_s) begin
                    if (SIGNED != 0) begin
                        a_sh_d = {{W{a1_s[W-1]}}, a1_s};
                    end else begin
                        a_sh_d = {{W{1'b0}}, a1_s};
                    end
                    b_sh_d  = b1_s;
                    acc_d   = {PW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    ko_d    = 1'b0;
                    state_d = MULT;
                end else begin
                    state_d = IDLE;
                end
            end
            MULT: begin
                // Two's-complement weight of the B sign bit is negative, hence the final subtract
                if (b_sh_q[0]) begin
                    if ((SIGNED != 0) && (cnt_q == CW'(W - 1))) begin
                        acc_d = acc_q - a_sh_q;
                    end else begin
                        acc_d = acc_q + a_sh_q;
                    end
                end else begin
                    acc_d = acc_q;
                end
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = HOLD;
                end else begin
                    state_d = MULT;
                end
            end
            HOLD: begin
                if (ki2_q && !blocked_s) begin
                    p1_d    = acc_q;
                    p0_d    = ~acc_q;
                    state_d = PRESENT;
                end else begin
                    state_d = HOLD;
                end
            end
            PRESENT: begin
                if (!ki2_q) begin
                    p1_d    = {PW{1'b0}};
                    p0_d    = {PW{1'b0}};
                    state_d = IDLE;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                p1_d    = {PW{1'b0}};
                p0_d    = {PW{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync1_q <= {NR{1'b0}};
            sync2_q <= {NR{1'b0}};
            prev_q  <= {NR{1'b0}};
            ki1_q   <= 1'b0;
            ki2_q   <= 1'b0;
            ko_q    <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {PW{1'b0}};
            a_sh_q  <= {PW{1'b0}};
            b_sh_q  <= {W{1'b0}};
            p1_q    <= {PW{1'b0}};
            p0_q    <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ki1_q   <= ki1_d;
            ki2_q   <= ki2_d;
            ko_q    <= ko_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            p1_q    <= p1_d;
            p0_q    <= p0_d;
        end
    end

    assign Ko      = ko_q;
    assign p_rail1 = p1_q;
    assign p_rail0 = p0_q;
    assign err     = err_q;

endmodule
